// File: rtl/reg_file_param_pkg.sv
// Shared types and default sizes for the parameterised register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package reg_file_param_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  // Clear sequencer states: CLEAR sweeps zeros through the array, IDLE serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear-sweep sequencer: FSM plus sweep index. While in CLEAR it issues one
// zero-write per cycle at idx_o, walking 0..DEPTH-1, then drops to IDLE.
// Busy is a pure decode of the state register, so it has no input path.
module reg_file_clr_seq
  import reg_file_param_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEFAULT_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_req_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // State and index registers; reset parks the sequencer at the start of a sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: sweep one entry per cycle; a clear request only counts in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o   = (state_q == CLEAR);
  assign clr_we_o = (state_q == CLEAR);
  assign idx_o    = idx_q;

endmodule

// File: rtl/reg_file_param.sv
// Two-read / one-write register file with a self-clearing sweep after reset or
// on request. Storage has no reset: contents are zeroed by the sweep only.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, an IDLE read of the
// address being written returns Writedata in the same cycle.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] Raddr1,
  input  logic [ADDR_W-1:0] Raddr2,
  output logic [DATA_W-1:0] Read1,
  output logic [DATA_W-1:0] Read2,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [DATA_W-1:0] Writedata,
  input  logic              RegWr,
  input  logic              ClrReq,
  output logic              Busy
);

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              clr_we;
  logic [IDX_W-1:0]  clr_idx;
  logic              user_we;

  // An address is usable if it maps to a real entry and is not the hardwired r0.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_A) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  reg_file_clr_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clr_seq (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .clr_req_i (ClrReq),
    .busy_o    (Busy),
    .clr_we_o  (clr_we),
    .idx_o     (clr_idx)
  );

  // User write qualifier: blocked during a sweep and on the cycle a clear is requested.
  always_comb begin
    user_we = RegWr && !Busy && !ClrReq && addr_ok(Waddr);
  end

  // Storage update: sweep zero-writes take priority over user writes.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      regs_q[clr_idx] <= '0;
    end else if (user_we) begin
      regs_q[Waddr[IDX_W-1:0]] <= Writedata;
    end
  end

  // Read mux shared by both ports: zero while clearing or for unusable addresses.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (!Busy && addr_ok(a)) begin
      v = regs_q[a[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
      if (user_we && (a == Waddr)) begin
        v = Writedata;
      end
`endif
    end
    return v;
  endfunction

  // Combinational read ports.
  always_comb begin
    Read1 = rd_port(Raddr1);
    Read2 = rd_port(Raddr2);
  end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, register width in bits.
- DEPTH, 16, number of registers; range 2..32.
- ADDR_W, 5, address width; SHALL satisfy 2**ADDR_W >= DEPTH.
- ZERO_R0, 0, when 1 register 0 reads as zero and ignores writes.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, input, 1, single clock; all state updates on rising edge.
- RESET, input, 1, asynchronous active-low reset.
- Raddr1, input, ADDR_W, read port 1 address.
- Raddr2, input, ADDR_W, read port 2 address.
- Read1, output, DATA_W, read port 1 data.
- Read2, output, DATA_W, read port 2 data.
- Waddr, input, ADDR_W, write address.
- Writedata, input, DATA_W, write data.
- RegWr, input, 1, write enable.
- ClrReq, input, 1, one-cycle pulse requesting a full clear sweep.
- Busy, output, 1, high while the clear sweep runs.

REQ-003 There SHALL be one clock and the reset SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be CLEAR and IDLE.
REQ-005 Deasserting RESET SHALL enter CLEAR with sweep index 0.
REQ-006 In CLEAR, each cycle SHALL write zero to the register at the sweep index, then increment the index.
REQ-007 The FSM SHALL go CLEAR->IDLE on the cycle the index DEPTH-1 is written; a sweep takes exactly DEPTH cycles.
REQ-008 In IDLE, ClrReq=1 SHALL go IDLE->CLEAR with index 0.
- If RegWr is also 1 in that cycle, the write SHALL be dropped.
REQ-009 ClrReq in CLEAR SHALL be ignored; the sweep does not restart.
REQ-010 Busy SHALL be 1 exactly when the state is CLEAR, registered, with no combinational path from inputs.
REQ-011 In CLEAR, RegWr SHALL be ignored and Read1/Read2 SHALL return 0.
REQ-012 In IDLE, RegWr=1 with Waddr<DEPTH SHALL update registers[Waddr] on the rising edge.
REQ-013 A write with Waddr>=DEPTH SHALL be ignored.
REQ-014 Reads SHALL be combinational: Read1 = registers[Raddr1] and Read2 = registers[Raddr2].
- An address >= DEPTH SHALL read 0.
REQ-015 Both read ports MAY address the same register and SHALL both return its value.
REQ-016 With ZERO_R0=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be ignored.
REQ-017 There SHALL be no $display or other simulation side effects in RTL.

Reset
REQ-018 RESET low SHALL immediately force state CLEAR, index 0, Busy=1, and Read1=Read2=0.
- Register contents SHALL be cleared by the sweep, not by the asynchronous reset.
REQ-019 RESET asserted mid-sweep or mid-write SHALL abort the operation and restart the sweep from index 0 after release.

Configuration
REQ-020 With REGFILE_BYPASS_EN defined, an IDLE read whose address equals Waddr while RegWr=1 SHALL return Writedata in the same cycle.
- Bypass applies only when Waddr<DEPTH and the write is not suppressed by ZERO_R0.
REQ-021 With REGFILE_BYPASS_EN undefined, that read SHALL return the pre-write value, and the new value SHALL be visible from the next cycle.

Structure
REQ-022 A shared package SHALL hold the FSM state typedef (CLEAR, IDLE) and the default DATA_W and DEPTH constants.
REQ-023 The sweep index counter plus FSM SHALL be one sub-module, reg_file_clr_seq, with outputs Busy, clear-write enable and index.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Release RESET with DEPTH=16 -> Busy=1 for exactly 16 cycles, then all 16 registers read 0.
- In IDLE, write 0xDEADBEEF to r5, then read r5 on both ports -> both return 0xDEADBEEF on the next cycle.
- Same-cycle write of 0x1234 to r3 with Raddr1=3 -> 0x1234 with REGFILE_BYPASS_EN defined, old value without it.
- Pulse ClrReq with RegWr=1 to r7 -> write dropped, Busy=1 for 16 cycles, r7 reads 0.
- Assert RESET at cycle 8 of a sweep -> Busy stays 1 and a full 16-cycle sweep restarts after release.
- Use ZERO_R0=1 and an out-of-range address (Waddr=20 with DEPTH=16) -> write r0=0xFF reads 0, and Raddr1=20 reads 0.
